// File: rtl/tag_pkg.sv
// Shared definitions for the free-tag list: default sizes, a clog2 helper,
// the tag type and the free-count width.
package tag_pkg;

    localparam int W_TAG_DEF = 6;
    localparam int N_TAG_DEF = 64;

    // Number of bits needed to encode the values 0..v-1 (v >= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) r = i + 1;
        end
        return r;
    endfunction

    typedef logic [W_TAG_DEF-1:0] tag_t;

    // Width of free_count for the default configuration (must hold N_TAG itself).
    localparam int FC_W_DEF = clog2(N_TAG_DEF + 1);

endpackage

// File: rtl/tag_freelist_ret_compact.sv
// Combinational return filter for the free-tag list. Walks the return channels
// in order, drops out-of-range (and, with TAG_FREELIST_DUP_CHECK_EN, stale or
// duplicate) tags, and packs the survivors into consecutive write offsets up to
// the capacity available this cycle.
module tag_freelist_ret_compact
    import tag_pkg::*;
#(
    parameter int W_TAG = W_TAG_DEF,
    parameter int N_TAG = N_TAG_DEF,
    parameter int N_RET = 2,
    parameter int CW    = clog2(N_TAG + 1),
    parameter int OW    = clog2(N_RET + 1)
) (
    input  logic [N_RET-1:0]       ret_valid,
    input  logic [N_RET*W_TAG-1:0] ret_tag,
    input  logic [CW-1:0]          cap,
`ifdef TAG_FREELIST_DUP_CHECK_EN
    input  logic [N_TAG-1:0]       inflight,
`endif
    output logic [N_RET-1:0]       accept,
    output logic [N_RET*OW-1:0]    offset,
    output logic [OW-1:0]          acc_cnt,
    output logic                   err
);

    // Channel-ordered accept/drop decision with running write offset.
    always_comb begin
        int               cnt;
        logic [W_TAG-1:0] tag;
        logic             drop;
        accept = '0;
        offset = '0;
        err    = 1'b0;
        cnt    = 0;
        tag    = '0;
        drop   = 1'b0;
        for (int k = 0; k < N_RET; k++) begin
            tag  = ret_tag[k*W_TAG +: W_TAG];
            drop = 1'b0;
            if (ret_valid[k]) begin
                if (int'(tag) >= N_TAG) begin
                    drop = 1'b1;
                end
`ifdef TAG_FREELIST_DUP_CHECK_EN
                else if (!inflight[tag]) begin
                    drop = 1'b1;
                end else begin
                    // Any earlier valid channel carrying the same tag wins.
                    for (int j = 0; j < k; j++) begin
                        if (ret_valid[j] && (ret_tag[j*W_TAG +: W_TAG] == tag)) drop = 1'b1;
                    end
                end
`endif
                if (drop) begin
                    err = 1'b1;
                end else if (cnt < int'(cap)) begin
                    accept[k]           = 1'b1;
                    offset[k*OW +: OW]  = OW'(cnt);
                    cnt                 = cnt + 1;
                end else begin
                    err = 1'b1;
                end
            end
        end
        acc_cnt = OW'(cnt);
    end

endmodule

// File: rtl/tag_freelist.sv
// Free rename-tag list: circular buffer of tags with one allocation per cycle,
// up to N_RET returns per cycle and single-cycle flush to the full tag set.
// Optional feature macro: TAG_FREELIST_DUP_CHECK_EN adds an in-flight vector
// that rejects returns of tags not currently allocated or duplicated in-cycle.
module tag_freelist
    import tag_pkg::*;
#(
    parameter int W_TAG = W_TAG_DEF,
    parameter int N_TAG = N_TAG_DEF,
    parameter int N_RET = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc_ren,
    output logic                           alloc_valid,
    output logic [W_TAG-1:0]               alloc_tag,
    input  logic [N_RET-1:0]               ret_valid,
    input  logic [N_RET*W_TAG-1:0]         ret_tag,
    input  logic                           flush,
    output logic [clog2(N_TAG + 1)-1:0]    free_count,
    output logic                           full,
    output logic                           ret_err
);

    localparam int CW = clog2(N_TAG + 1);
    localparam int PW = clog2(N_TAG);
    localparam int OW = clog2(N_RET + 1);

    logic [W_TAG-1:0]    mem_q [N_TAG];
    logic [W_TAG-1:0]    mem_d [N_TAG];
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [PW-1:0]       wptr_q, wptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ret_err_q, ret_err_d;

    logic                pop;
    logic [CW-1:0]       cap;
    logic [N_RET-1:0]    accept;
    logic [N_RET*OW-1:0] offset;
    logic [OW-1:0]       acc_cnt;
    logic                ret_err_strobe;

`ifdef TAG_FREELIST_DUP_CHECK_EN
    logic [N_TAG-1:0]    inflight_q, inflight_d;
`endif

    // Outputs come from registered state only; alloc_ren does not feed them.
    always_comb begin
        alloc_valid = (count_q != '0);
        alloc_tag   = mem_q[rptr_q];
        free_count  = count_q;
        full        = (count_q == CW'(N_TAG));
        ret_err     = ret_err_q;
    end

    // Pop qualification and capacity left for returns this cycle.
    always_comb begin
        pop = alloc_ren & alloc_valid;
        cap = CW'(N_TAG) - count_q + CW'(pop);
    end

    tag_freelist_ret_compact #(
        .W_TAG (W_TAG),
        .N_TAG (N_TAG),
        .N_RET (N_RET),
        .CW    (CW),
        .OW    (OW)
    ) u_ret_compact (
        .ret_valid (ret_valid),
        .ret_tag   (ret_tag),
        .cap       (cap),
`ifdef TAG_FREELIST_DUP_CHECK_EN
        .inflight  (inflight_q),
`endif
        .accept    (accept),
        .offset    (offset),
        .acc_cnt   (acc_cnt),
        .err       (ret_err_strobe)
    );

    // Next-state for storage, pointers, count and sticky error; flush wins.
    always_comb begin
        int widx;
        int wsum;
        mem_d     = mem_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        ret_err_d = ret_err_q;
        widx      = 0;
        wsum      = 0;
        if (flush) begin
            for (int i = 0; i < N_TAG; i++) mem_d[i] = W_TAG'(i);
            rptr_d    = '0;
            wptr_d    = '0;
            count_d   = CW'(N_TAG);
            ret_err_d = 1'b0;
        end else begin
            for (int k = 0; k < N_RET; k++) begin
                if (accept[k]) begin
                    // Compare-and-wrap: offset < cap <= N_TAG, so one subtract suffices.
                    widx = int'(wptr_q) + int'(offset[k*OW +: OW]);
                    if (widx >= N_TAG) widx = widx - N_TAG;
                    mem_d[PW'(widx)] = ret_tag[k*W_TAG +: W_TAG];
                end
            end
            if (pop) begin
                rptr_d = (rptr_q == PW'(N_TAG - 1)) ? '0 : rptr_q + PW'(1);
            end
            wsum = int'(wptr_q) + int'(acc_cnt);
            if (wsum >= N_TAG) wsum = wsum - N_TAG;
            wptr_d    = PW'(wsum);
            count_d   = count_q - CW'(pop) + CW'(acc_cnt);
            ret_err_d = ret_err_q | ret_err_strobe;
        end
    end

    // State registers; reset restores the identity tag list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_TAG; i++) mem_q[i] <= W_TAG'(i);
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= CW'(N_TAG);
            ret_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_TAG; i++) mem_q[i] <= mem_d[i];
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            ret_err_q <= ret_err_d;
        end
    end

`ifdef TAG_FREELIST_DUP_CHECK_EN
    // In-flight tracking: clear on accepted return, set on pop.
    always_comb begin
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else begin
            for (int k = 0; k < N_RET; k++) begin
                if (accept[k]) inflight_d[ret_tag[k*W_TAG +: W_TAG]] = 1'b0;
            end
            if (pop) inflight_d[alloc_tag] = 1'b1;
        end
    end

    // In-flight vector register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) inflight_q <= '0;
        else       inflight_q <= inflight_d;
    end
`endif

endmodule

// File: tb/tb_tag_freelist.sv
// Self-checking bench for tag_freelist: a 64-tag instance for the in-order
// allocation sweep and a 48-tag instance driven against a queue scoreboard.
module tb_tag_freelist;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 64-tag instance
    logic        ren64;
    logic        av64;
    logic [5:0]  at64;
    logic [1:0]  rv64;
    logic [11:0] rt64;
    logic        fl64;
    logic [6:0]  fc64;
    logic        full64;
    logic        err64;

    // 48-tag instance
    logic        ren48;
    logic        av48;
    logic [5:0]  at48;
    logic [1:0]  rv48;
    logic [11:0] rt48;
    logic        fl48;
    logic [5:0]  fc48;
    logic        full48;
    logic        err48;

    tag_freelist #(.W_TAG(6), .N_TAG(64), .N_RET(2)) dut64 (
        .clk         (clk),
        .reset       (reset),
        .alloc_ren   (ren64),
        .alloc_valid (av64),
        .alloc_tag   (at64),
        .ret_valid   (rv64),
        .ret_tag     (rt64),
        .flush       (fl64),
        .free_count  (fc64),
        .full        (full64),
        .ret_err     (err64)
    );

    tag_freelist #(.W_TAG(6), .N_TAG(48), .N_RET(2)) dut48 (
        .clk         (clk),
        .reset       (reset),
        .alloc_ren   (ren48),
        .alloc_valid (av48),
        .alloc_tag   (at48),
        .ret_valid   (rv48),
        .ret_tag     (rt48),
        .flush       (fl48),
        .free_count  (fc48),
        .full        (full48),
        .ret_err     (err48)
    );

    int checks = 0;
    int passed = 0;

    // Scoreboard for the 48-tag instance: free tags in allocation order.
    int exp48[$];
    bit exp_err48;
    int q64[$];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic model_reset48();
        exp48.delete();
        for (int i = 0; i < 48; i++) exp48.push_back(i);
        exp_err48 = 1'b0;
    endtask

    task automatic check48(input string name);
        chk({name, ".valid"}, 32'(av48), 32'(exp48.size() != 0));
        chk({name, ".count"}, 32'(fc48), 32'(exp48.size()));
        chk({name, ".full"}, 32'(full48), 32'(exp48.size() == 48));
        chk({name, ".err"}, 32'(err48), 32'(exp_err48));
        if (exp48.size() != 0) chk({name, ".tag"}, 32'(at48), 32'(exp48[0]));
    endtask

    // Drive one cycle on the 48-tag instance (called at a negedge), update the
    // scoreboard, then check outputs at the following negedge.
    task automatic step48(input string name, input bit ren, input bit v0, input int t0,
                          input bit v1, input int t1, input bit fl);
        bit vv[2];
        int tt[2];
        int cap;
        int k;
        bit pop;
        ren48 = ren;
        rv48  = {v1, v0};
        rt48  = {6'(t1), 6'(t0)};
        fl48  = fl;
        vv[0] = v0; vv[1] = v1;
        tt[0] = t0; tt[1] = t1;
        if (fl) begin
            model_reset48();
        end else begin
            pop = ren && (exp48.size() != 0);
            cap = 48 - exp48.size() + (pop ? 1 : 0);
            if (pop) void'(exp48.pop_front());
            k = 0;
            for (int c = 0; c < 2; c++) begin
                if (vv[c]) begin
                    if (tt[c] >= 48) exp_err48 = 1'b1;
                    else if (k < cap) begin
                        exp48.push_back(tt[c]);
                        k++;
                    end else exp_err48 = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        ren48 = 1'b0;
        rv48  = '0;
        rt48  = '0;
        fl48  = 1'b0;
        check48(name);
    endtask

    initial begin
        reset = 1'b1;
        ren64 = 1'b0; rv64 = '0; rt64 = '0; fl64 = 1'b0;
        ren48 = 1'b0; rv48 = '0; rt48 = '0; fl48 = 1'b0;
        model_reset48();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check48("rst48");
        chk("rst64.valid", 32'(av64), 32'd1);
        chk("rst64.tag", 32'(at64), 32'd0);
        chk("rst64.count", 32'(fc64), 32'd64);
        chk("rst64.full", 32'(full64), 32'd1);
        chk("rst64.err", 32'(err64), 32'd0);

        // 64 back-to-back pops, tags in order
        for (int i = 0; i < 64; i++) q64.push_back(i);
        for (int i = 0; i < 64; i++) begin
            chk("p64.tag", 32'(at64), 32'(q64.pop_front()));
            chk("p64.valid", 32'(av64), 32'd1);
            ren64 = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        ren64 = 1'b0;
        chk("p64.empty_valid", 32'(av64), 32'd0);
        chk("p64.empty_count", 32'(fc64), 32'd0);
        // Pop on empty is ignored
        ren64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ren64 = 1'b0;
        chk("p64.empty_pop_count", 32'(fc64), 32'd0);

        // Drain 48, return a permutation two per cycle, drain again (wraps both pointers)
        for (int i = 0; i < 48; i++) step48("drain1", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 24; i++)
            step48("refill", 1'b0, 1'b1, (2 * i * 7) % 48, 1'b1, ((2 * i + 1) * 7) % 48, 1'b0);
        for (int i = 0; i < 48; i++) step48("drain2", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

        // Empty: returns 5/9 with a pop request that must not bypass
        step48("empty_ret", 1'b1, 1'b1, 5, 1'b1, 9, 1'b0);
        chk("empty_ret.tag5", 32'(at48), 32'd5);
        step48("pop5", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("pop5.tag9", 32'(at48), 32'd9);
        step48("pop9", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

        // Restore full, then return onto a full list: dropped, error set
        step48("flush_full", 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        step48("full_ret", 1'b0, 1'b1, 3, 1'b0, 0, 1'b0);
        chk("full_ret.err", 32'(err48), 32'd1);
        chk("full_ret.count", 32'(fc48), 32'd48);

        // Pop 10 then flush with simultaneous pop and return
        for (int i = 0; i < 10; i++) step48("pop10", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        step48("flush_mix", 1'b1, 1'b1, 2, 1'b0, 0, 1'b1);
        chk("flush_mix.count", 32'(fc48), 32'd48);
        chk("flush_mix.tag", 32'(at48), 32'd0);
        chk("flush_mix.err", 32'(err48), 32'd0);

        // Out-of-range return with room available
        step48("pop_a", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        step48("pop_b", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        step48("oor", 1'b0, 1'b1, 50, 1'b1, 1, 1'b0);
        chk("oor.err", 32'(err48), 32'd1);

`ifndef TAG_FREELIST_DUP_CHECK_EN
        // Full list with pop and return together: read sees pre-write value
        step48("flush2", 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        step48("full_popret", 1'b1, 1'b1, 33, 1'b0, 0, 1'b0);
        for (int i = 0; i < 47; i++) step48("drain3", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("drain3.tag33", 32'(at48), 32'd33);
`endif

        // Pop tag 0 and return it on both channels: one accepted, error set
        step48("flush3", 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        step48("pop0", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        step48("dup_ret", 1'b0, 1'b1, 0, 1'b1, 0, 1'b0);
        chk("dup_ret.err", 32'(err48), 32'd1);
        chk("dup_ret.count", 32'(fc48), 32'd48);

        // Asynchronous reset mid-operation takes effect without a clock edge
        step48("pre_rst", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst.count", 32'(fc48), 32'd48);
        chk("async_rst.tag", 32'(at48), 32'd0);
        chk("async_rst.err", 32'(err48), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset48();
        @(negedge clk);
        check48("post_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
